// File: rtl/lsu_mem_master.sv
// Load/store initiator: one request at a time, misaligned h/w split into byte accesses (MISALIGN_TRAP_EN traps them instead).
// Latency accept->rsp_valid: aligned 2, split N+1, error 1; response held until rsp_ready, no request accepted while busy.
module lsu_mem_master #(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_W    = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_ctrl,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_dm_addr,
    output logic [31:0]       o_dm_wdata,
    output logic              o_dm_wr,
    output logic [2:0]        o_dm_ctrl,
    input  logic [31:0]       i_dm_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SPLIT, S_RESP} state_t;

    localparam logic [ADDR_W-1:0] LP_MEM_BYTES = ADDR_W'(MEM_BYTES);
    localparam logic [2:0]        LP_DM_IDLE   = 3'b011;
`ifdef MISALIGN_TRAP_EN
    localparam bit LP_TRAP = 1'b1;
`else
    localparam bit LP_TRAP = 1'b0;
`endif

    state_t            r_state, w_next;
    logic              r_we;
    logic [2:0]        r_ctrl;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_cnt;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              w_accept, w_ctrl_ok, w_range_err, w_misalign, w_acc_err;
    logic [ADDR_W-1:0] w_size, w_last;
    logic [1:0]        w_cnt_last;
    logic [7:0]        w_wbyte;
    logic [31:0]       w_asm, w_ext;

    assign w_accept  = i_req_valid && (r_state == S_IDLE);
    assign w_ctrl_ok = (i_req_ctrl == 3'b000) || (i_req_ctrl == 3'b001) || (i_req_ctrl == 3'b010) ||
                       (i_req_ctrl == 3'b100) || (i_req_ctrl == 3'b101);

    always_comb begin
        w_size = ADDR_W'(1);
        case (i_req_ctrl[1:0])
            2'b01:   w_size = ADDR_W'(2);
            2'b10:   w_size = ADDR_W'(4);
            default: w_size = ADDR_W'(1);
        endcase
    end

    // The first-byte check also catches a last byte that wrapped past 2^ADDR_W.
    assign w_last      = i_req_addr + w_size - ADDR_W'(1);
    assign w_range_err = (i_req_addr >= LP_MEM_BYTES) || (w_last >= LP_MEM_BYTES);
    assign w_misalign  = ((i_req_ctrl[1:0] == 2'b01) && i_req_addr[0]) ||
                         ((i_req_ctrl[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
    assign w_acc_err   = !w_ctrl_ok || w_range_err || (LP_TRAP && w_misalign);
    assign w_cnt_last  = (r_ctrl[1:0] == 2'b10) ? 2'd3 : 2'd1;

    always_comb begin
        w_wbyte = r_wdata[7:0];
        w_asm   = r_rdata;
        case (r_cnt)
            2'd0: begin w_wbyte = r_wdata[7:0];   w_asm[7:0]   = i_dm_rdata[7:0]; end
            2'd1: begin w_wbyte = r_wdata[15:8];  w_asm[15:8]  = i_dm_rdata[7:0]; end
            2'd2: begin w_wbyte = r_wdata[23:16]; w_asm[23:16] = i_dm_rdata[7:0]; end
            default: begin w_wbyte = r_wdata[31:24]; w_asm[31:24] = i_dm_rdata[7:0]; end
        endcase
    end

    always_comb begin
        w_ext = w_asm;
        case (r_ctrl)
            3'b001:  w_ext = {{16{w_asm[15]}}, w_asm[15:0]};
            3'b101:  w_ext = {16'b0, w_asm[15:0]};
            default: w_ext = w_asm;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_acc_err)       w_next = S_RESP;
                    else if (w_misalign) w_next = S_SPLIT;
                    else                 w_next = S_ACCESS;
                end
            end
            S_ACCESS: w_next = S_RESP;
            S_SPLIT:  if (r_cnt == w_cnt_last) w_next = S_RESP;
            S_RESP:   if (i_rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_dm_addr  = '0;
        o_dm_wdata = '0;
        o_dm_wr    = 1'b0;
        o_dm_ctrl  = LP_DM_IDLE;
        case (r_state)
            S_ACCESS: begin
                o_dm_addr  = r_addr;
                o_dm_wdata = r_wdata;
                o_dm_wr    = r_we;
                o_dm_ctrl  = r_ctrl;
            end
            S_SPLIT: begin
                o_dm_addr  = r_addr + ADDR_W'(r_cnt);
                o_dm_wdata = {24'b0, w_wbyte};
                o_dm_wr    = r_we;
                o_dm_ctrl  = 3'b100;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_ctrl  <= LP_DM_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= 2'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= i_req_we;
                        r_ctrl  <= i_req_ctrl;
                        r_addr  <= i_req_addr;
                        r_wdata <= i_req_wdata;
                        r_cnt   <= 2'd0;
                        r_rdata <= '0;
                        r_err   <= w_acc_err;
                    end
                end
                S_ACCESS: if (!r_we) r_rdata <= i_dm_rdata;
                S_SPLIT: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (!r_we) r_rdata <= (r_cnt == w_cnt_last) ? w_ext : w_asm;
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready = (r_state == S_IDLE);
    assign o_rsp_valid = (r_state == S_RESP);
    assign o_rsp_rdata = r_rdata;
    assign o_rsp_err   = r_err;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a little-endian byte memory model; honours MISALIGN_TRAP_EN.
module tb_lsu_mem_master;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [2:0]  req_ctrl = 3'b000;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_rdata, dm_addr, dm_wdata, dm_rdata;
    logic        dm_wr;
    logic [2:0]  dm_ctrl;

    logic [7:0]  mem [0:4095];
    logic        mem_clr = 1'b1;
    int          n_wr = 0, n_act = 0;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    lsu_mem_master #(.MEM_BYTES(4096), .ADDR_W(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_ctrl(req_ctrl), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_dm_addr(dm_addr), .o_dm_wdata(dm_wdata), .o_dm_wr(dm_wr), .o_dm_ctrl(dm_ctrl),
        .i_dm_rdata(dm_rdata)
    );

    logic [11:0] rd_a;
    logic [31:0] rd_w;
    always_comb begin
        rd_a = dm_addr[11:0];
        rd_w = {mem[rd_a + 12'd3], mem[rd_a + 12'd2], mem[rd_a + 12'd1], mem[rd_a]};
        dm_rdata = '0;
        case (dm_ctrl)
            3'b000:  dm_rdata = {{24{rd_w[7]}}, rd_w[7:0]};
            3'b100:  dm_rdata = {24'b0, rd_w[7:0]};
            3'b001:  dm_rdata = {{16{rd_w[15]}}, rd_w[15:0]};
            3'b101:  dm_rdata = {16'b0, rd_w[15:0]};
            3'b010:  dm_rdata = rd_w;
            default: dm_rdata = '0;
        endcase
    end

    // Memory acts mid-cycle, when the DUT's combinational port is settled.
    always @(negedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
        end else if (!rst) begin
            if (dm_ctrl != 3'b011) n_act <= n_act + 1;
            if (dm_wr) begin
                n_wr <= n_wr + 1;
                mem[dm_addr[11:0]] <= dm_wdata[7:0];
                if (dm_ctrl[1:0] != 2'b00) mem[dm_addr[11:0] + 12'd1] <= dm_wdata[15:8];
                if (dm_ctrl[1:0] == 2'b10) begin
                    mem[dm_addr[11:0] + 12'd2] <= dm_wdata[23:16];
                    mem[dm_addr[11:0] + 12'd3] <= dm_wdata[31:24];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the edge raising rsp_valid.
    task automatic do_req(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                          output logic err, output int wr, output int act);
        int wr0, act0;
        wr0 = n_wr; act0 = n_act;
        req_valid = 1'b1; req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata; err = rsp_err;
        wr = n_wr - wr0; act = n_act - act0;
    endtask

    task automatic take;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic ld(input string tag, input logic [2:0] ctrl, input logic [31:0] addr,
                      input int exp_lat, input logic [31:0] exp_d, input logic exp_e);
        int lat, wr, act;
        logic [31:0] d;
        logic e;
        do_req(1'b0, ctrl, addr, 32'h0, lat, d, e, wr, act);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, d, exp_d);
        chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_e});
        take();
    endtask

    task automatic st(input string tag, input logic [2:0] ctrl, input logic [31:0] addr,
                      input logic [31:0] wdata, input int exp_lat, input int exp_wr, input logic exp_e);
        int lat, wr, act;
        logic [31:0] d;
        logic e;
        do_req(1'b1, ctrl, addr, wdata, lat, d, e, wr, act);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_wr"}, 32'(wr), 32'(exp_wr));
        chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_e});
        take();
    endtask

    initial begin
        int lat, wr, act, bad;
        logic [31:0] d, d0;
        logic e;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_dm_wr", {31'b0, dm_wr}, 32'd0);
        chk("rst_dm_ctrl", {29'b0, dm_ctrl}, 32'h3);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_dm_wdata", dm_wdata, 32'h0);
        mem_clr = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Aligned word store then load back
        st("st_w10", 3'b010, 32'h10, 32'hDEADBEEF, 2, 1, 1'b0);
        ld("ld_w10", 3'b010, 32'h10, 2, 32'hDEADBEEF, 1'b0);

        // Byte store then signed / unsigned byte loads
        st("st_b13", 3'b000, 32'h13, 32'h123456EF, 2, 1, 1'b0);
        ld("ld_b13", 3'b000, 32'h13, 2, 32'hFFFFFFEF, 1'b0);
        ld("ld_bu13", 3'b100, 32'h13, 2, 32'h000000EF, 1'b0);

        // Misaligned half store, half/hu loads, misaligned word load over 0x11..0x14
        st("st_h21", 3'b001, 32'h21, 32'h00008001, TRAP ? 1 : 3, TRAP ? 0 : 2, TRAP);
        ld("ld_h21", 3'b001, 32'h21, TRAP ? 1 : 3, TRAP ? 32'h0 : 32'hFFFF8001, TRAP);
        ld("ld_hu21", 3'b101, 32'h21, TRAP ? 1 : 3, TRAP ? 32'h0 : 32'h00008001, TRAP);
        ld("ld_bu21", 3'b100, 32'h21, 2, TRAP ? 32'h0 : 32'h01, 1'b0);
        ld("ld_bu22", 3'b100, 32'h22, 2, TRAP ? 32'h0 : 32'h80, 1'b0);
        ld("ld_w11", 3'b010, 32'h11, TRAP ? 1 : 5, TRAP ? 32'h0 : 32'h00EFADBE, TRAP);

        // Range and ctrl-code errors, plus in-range boundary accesses
        do_req(1'b0, 3'b010, 32'hFFE, 32'h0, lat, d, e, wr, act);
        chk("oor_w_err", {31'b0, e}, 32'd1);
        chk("oor_w_rdata", d, 32'h0);
        chk("oor_w_lat", 32'(lat), 32'd1);
        chk("oor_w_act", 32'(act), 32'd0);
        take();
        ld("bad_ctrl", 3'b011, 32'h10, 1, 32'h0, 1'b1);
        ld("ld_wFFC", 3'b010, 32'hFFC, 2, 32'h0, 1'b0);
        ld("ld_b1000", 3'b000, 32'h1000, 1, 32'h0, 1'b1);
        ld("ld_bFFF", 3'b000, 32'hFFF, 2, 32'h0, 1'b0);

        // Response held under backpressure; a new request during the hold is ignored
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, d0, e, wr, act);
        chk("hold_first", d0, 32'hEFADBEEF);
        bad = 0;
        act = n_act;
        req_valid = 1'b1; req_we = 1'b1; req_ctrl = 3'b010; req_addr = 32'h40; req_wdata = 32'h55555555;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== d0 || req_ready !== 1'b0) bad++;
        end
        req_valid = 1'b0;
        chk("hold_stable", 32'(bad), 32'd0);
        chk("hold_no_act", 32'(n_act - act), 32'd0);
        take();
        chk("release_ready", {31'b0, req_ready}, 32'd1);
        chk("release_valid", {31'b0, rsp_valid}, 32'd0);

        // Reset in the middle of a split word store
        st("pre33", 3'b000, 32'h33, 32'hAA, 2, 1, 1'b0);
        st("pre34", 3'b000, 32'h34, 32'hBB, 2, 1, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_ctrl = 3'b010; req_addr = 32'h31; req_wdata = 32'h11223344;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_dm_wr", {31'b0, dm_wr}, 32'd0);
        chk("mid_rst_dm_ctrl", {29'b0, dm_ctrl}, 32'h3);
        chk("mid_rst_dm_addr", dm_addr, 32'h0);
        chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        ld("rb31", 3'b100, 32'h31, 2, TRAP ? 32'h0 : 32'h44, 1'b0);
        ld("rb32", 3'b100, 32'h32, 2, TRAP ? 32'h0 : 32'h33, 1'b0);
        ld("rb33", 3'b100, 32'h33, 2, 32'hAA, 1'b0);
        ld("rb34", 3'b100, 32'h34, 2, 32'hBB, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
